model_sel_signal: RTL and testbench
===================================

# model_sel_signal

Runtime-selectable, registered successor to the static signal picker. It selects one word from a HEIGHT-deep array of WIDTH-bit inputs. The select comes from a loadable pointer, either held fixed or auto-advanced round-robin. The selected word and its index are delivered through a one-entry valid/ready output register. It sits between banks of per-slave/per-register status words and a single downstream consumer such as a readback or monitor path.

## Interface
- WIDTH, 32, bit width of each input word and of `out`
- HEIGHT, 32, number of input words; legal range 2..256, need not be a power of two
- RESET_SEL, 0, pointer value after reset; must be < HEIGHT
- SEL_W, $clog2(HEIGHT), derived pointer width; not overridden

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- in  input  [WIDTH-1:0] x [HEIGHT-1:0]  unpacked source array
- mode  input  1  0 = fixed select, 1 = round-robin scan
- en  input  1  capture enable
- sel_load  input  1  load `sel_in` into pointer
- sel_in  input  SEL_W  new pointer value
- out_ready  input  1  consumer accepts `out`
- out_valid  output  1  `out`/`out_sel` hold a captured word
- out  output  WIDTH  captured word
- out_sel  output  SEL_W  index the word was captured from
- sel_err  output  1  one-cycle pulse: rejected `sel_load`
- ptr  output  SEL_W  current pointer

## Operation
- Pointer `ptr` selects `in[ptr]` combinationally. Only the output stage is registered.
- Capture condition: `cap = en && (!out_valid || out_ready)`.
- On `cap`:
  - `out <= in[ptr]`, `out_sel <= ptr`, `out_valid <= 1`.
- Without `cap`:
  - If `out_valid && out_ready`, then `out_valid <= 0`.
  - Otherwise `out`, `out_sel` and `out_valid` hold. No data change is allowed while valid and not ready.
- Pointer update, in priority order:
  1. `sel_load && sel_in < HEIGHT`: `ptr <= sel_in`.
  2. `sel_load && sel_in >= HEIGHT`: pointer unchanged; `sel_err` pulses the next cycle.
  3. `mode==1 && cap`: `ptr <= (ptr == HEIGHT-1) ? 0 : ptr+1`.
  4. Otherwise `ptr` holds.
- `mode==0`: the pointer never auto-advances. Repeated captures return the same index.
- A legal load in the same cycle as a capture: the capture uses the old `ptr`, and the load wins over the scan increment.
- `mode` may change at any cycle. The change takes effect on the next pointer update only.

## Timing
- Reset values: `out=0`, `out_sel=0`, `out_valid=0`, `sel_err=0`, `ptr=RESET_SEL`.
- Reset asserted mid-transfer discards the held word with no handshake.
- Latency: `in[ptr]` sampled at edge N appears on `out` and `out_valid` after edge N. That is 1 cycle from `en`.
- Throughput: 1 word/cycle when `en` and `out_ready` are held high.
- Backpressure: with `out_valid=1` and `out_ready=0`, `out` and `out_sel` are stable and nothing is captured. The scan pointer does not advance, so no index is skipped.
- `sel_err` is registered, high for exactly one cycle per rejected load.
- Wrap: after `ptr=HEIGHT-1` is captured in scan mode, the next capture index is 0. This holds for non-power-of-two HEIGHT; `ptr` never reaches HEIGHT.
- `en=0` with `out_ready=1` drains the word: `out_valid` falls after one edge and `out` retains its last value.

## Test plan
- Reset default: WIDTH=32, HEIGHT=5, RESET_SEL=2, `in[k]=32'hA0+k`; release rst, en=1, mode=0, out_ready=1 -> `out_valid` rises one cycle later; `out=32'hA2`, `out_sel=2` every cycle; `ptr` stays 2.
- Scan wrap: same setup, mode=1 from reset -> `out_sel` sequence 2,3,4,0,1,2 on consecutive cycles with `out=32'hA0+out_sel`.
- Backpressure: mode=1, out_ready=0 for 4 cycles after the first capture (`out_sel=2`) -> `out` and `out_sel` hold 32'hA2/2 and `ptr` holds 3. Then out_ready=1 -> next outputs are 3, then 4.
- Illegal load: HEIGHT=5, sel_load=1, sel_in=6 -> `ptr` unchanged, `sel_err=1` for one cycle. Then sel_in=4 -> `ptr=4`, `sel_err=0`.
- Load during capture: mode=1, ptr=1, en=1, sel_load=1 with sel_in=3 in the same cycle -> the captured `out_sel` is 1; the next captures are 3, then 4.
- Reset mid-transfer: `out_valid=1`, out_ready=0, assert rst one cycle -> the next cycle shows `out_valid=0`, `out=0`, `out_sel=0`, `ptr=RESET_SEL`.

Source files
------------

// File: rtl/model_sel_signal.sv
// rtl/model_sel_signal.sv - pointer-selected word picker with registered valid/ready output stage
module model_sel_signal #(
  parameter  int WIDTH     = 32,
  parameter  int HEIGHT    = 32,
  parameter  int RESET_SEL = 0,
  localparam int SEL_W     = $clog2(HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in [HEIGHT-1:0],
  input  logic             mode,
  input  logic             en,
  input  logic             sel_load,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [SEL_W-1:0] out_sel,
  output logic             sel_err,
  output logic [SEL_W-1:0] ptr
);

  // One extra bit so HEIGHT itself is representable when HEIGHT is a power of two.
  localparam logic [SEL_W:0]   HEIGHT_X = (SEL_W+1)'(HEIGHT);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(HEIGHT - 1);
  localparam logic [SEL_W-1:0] RST_SEL  = SEL_W'(RESET_SEL);

  logic             cap;
  logic             sel_ok;
  logic [SEL_W-1:0] ptr_nxt;

  // A new word may enter only when the output register is empty or being drained this cycle.
  assign cap    = en && (!out_valid || out_ready);
  assign sel_ok = ({1'b0, sel_in} < HEIGHT_X);

  // Pointer next value: a load request (legal or not) pre-empts the scan step, so an
  // illegal load also suppresses that cycle's auto-advance.
  always_comb begin
    ptr_nxt = ptr;
    if (sel_load) begin
      if (sel_ok) begin
        ptr_nxt = sel_in;
      end
    end else if (mode && cap) begin
      ptr_nxt = (ptr == LAST_SEL) ? '0 : ptr + SEL_W'(1);
    end
  end

  // Pointer register and the one-cycle rejected-load flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= RST_SEL;
      sel_err <= 1'b0;
    end else begin
      ptr     <= ptr_nxt;
      sel_err <= sel_load && !sel_ok;
    end
  end

  // Output stage: capture in[ptr] using the pre-update pointer, hold under backpressure,
  // clear valid on a handshake with no new capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_sel   <= '0;
    end else if (cap) begin
      out_valid <= 1'b1;
      out       <= in[ptr];
      out_sel   <= ptr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_model_sel_signal.sv
// tb/tb_model_sel_signal.sv - directed bench with behavioural model for model_sel_signal
module tb_model_sel_signal;

  localparam int W  = 32;
  localparam int H  = 5;
  localparam int RS = 2;
  localparam int SW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_arr [H-1:0];
  logic          mode = 1'b0;
  logic          en = 1'b0;
  logic          sel_load = 1'b0;
  logic [SW-1:0] sel_in = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out;
  logic [SW-1:0] out_sel;
  logic          sel_err;
  logic [SW-1:0] ptr;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state
  int          m_ptr = RS;
  bit          m_valid = 0;
  int          m_sel = 0;
  logic [31:0] m_out = 0;
  bit          m_err = 0;

  model_sel_signal #(.WIDTH(W), .HEIGHT(H), .RESET_SEL(RS)) dut (
    .clk(clk), .rst(rst), .in(in_arr), .mode(mode), .en(en),
    .sel_load(sel_load), .sel_in(sel_in), .out_ready(out_ready),
    .out_valid(out_valid), .out(out), .out_sel(out_sel),
    .sel_err(sel_err), .ptr(ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: consumes the inputs seen at each rising edge and applies the block's rules.
  always @(posedge clk) begin
    bit cap;
    int nptr;
    if (rst) begin
      m_ptr = RS; m_valid = 0; m_sel = 0; m_out = 0; m_err = 0;
    end else begin
      cap  = en && (!m_valid || out_ready);
      nptr = m_ptr;
      if (sel_load) begin
        if (int'(sel_in) < H) nptr = int'(sel_in);
      end else if (mode && cap) begin
        nptr = (m_ptr + 1) % H;
      end
      m_err = sel_load && (int'(sel_in) >= H);
      if (cap) begin
        m_out = 32'hA0 + m_ptr; m_sel = m_ptr; m_valid = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      m_ptr = nptr;
    end
  end

  // Compare process: every falling edge after the first reset edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cmp_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("cmp_out", out, m_out);
      chk("cmp_out_sel", 32'(out_sel), 32'(m_sel));
      chk("cmp_sel_err", {31'b0, sel_err}, {31'b0, m_err});
      chk("cmp_ptr", 32'(ptr), 32'(m_ptr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; sel_load = 1'b0; mode = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  int seq [6] = '{2, 3, 4, 0, 1, 2};

  initial begin
    for (int k = 0; k < H; k++) in_arr[k] = 32'hA0 + k;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_ptr", 32'(ptr), 32'd2);

    // Fixed select
    en = 1'b1; mode = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fix_valid", {31'b0, out_valid}, 32'd1);
      chk("fix_out", out, 32'hA2);
      chk("fix_out_sel", 32'(out_sel), 32'd2);
      chk("fix_ptr", 32'(ptr), 32'd2);
    end
    // Drain
    en = 1'b0;
    step();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_out", out, 32'hA2);

    // Scan wrap
    do_reset();
    en = 1'b1; mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("wrap_out_sel", 32'(out_sel), 32'(seq[i]));
      chk("wrap_out", out, 32'hA0 + 32'(seq[i]));
    end

    // Backpressure
    do_reset();
    en = 1'b1; mode = 1'b1; out_ready = 1'b1;
    step();
    chk("bp_first_sel", 32'(out_sel), 32'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_hold_out", out, 32'hA2);
      chk("bp_hold_sel", 32'(out_sel), 32'd2);
      chk("bp_hold_ptr", 32'(ptr), 32'd3);
    end
    out_ready = 1'b1;
    step();
    chk("bp_rel_sel0", 32'(out_sel), 32'd3);
    step();
    chk("bp_rel_sel1", 32'(out_sel), 32'd4);

    // Illegal load
    do_reset();
    sel_load = 1'b1; sel_in = 3'd6;
    step();
    chk("ill_ptr", 32'(ptr), 32'd2);
    chk("ill_err", {31'b0, sel_err}, 32'd1);
    sel_in = 3'd4;
    step();
    chk("leg_ptr", 32'(ptr), 32'd4);
    chk("leg_err", {31'b0, sel_err}, 32'd0);
    sel_load = 1'b0;
    step();
    chk("err_idle", {31'b0, sel_err}, 32'd0);

    // Load during capture
    do_reset();
    sel_load = 1'b1; sel_in = 3'd1;
    step();
    chk("ldc_pre_ptr", 32'(ptr), 32'd1);
    mode = 1'b1; en = 1'b1; out_ready = 1'b1; sel_in = 3'd3;
    step();
    chk("ldc_cap_sel", 32'(out_sel), 32'd1);
    chk("ldc_ptr", 32'(ptr), 32'd3);
    sel_load = 1'b0;
    step();
    chk("ldc_next0", 32'(out_sel), 32'd3);
    step();
    chk("ldc_next1", 32'(out_sel), 32'd4);

    // Reset mid-transfer
    out_ready = 1'b0;
    step();
    chk("mid_valid_pre", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b0;
    chk("mid_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_out", out, 32'd0);
    chk("mid_out_sel", 32'(out_sel), 32'd0);
    chk("mid_ptr", 32'(ptr), 32'd2);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
